bcd_rr_arbiter: RTL and testbench

Ten-way round-robin arbiter sharing one resource among ten requesters. It issues the winner as a registered 4-bit BCD code (0–9) plus an active-low one-of-ten select bus, so existing BCD one-of-ten select decoding downstream lines up without change. Grants are break-before-make, with a mandatory idle gap between owners, and can optionally be pre-empted by a hold-time limit.

---
 rtl/bcd_arb_pkg.sv | 11 +
 rtl/bcd_sel_decode.sv | 13 +
 rtl/bcd_rr_arbiter.sv | 109 ++++++++++
 tb/tb_bcd_rr_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/bcd_arb_pkg.sv
// Shared types and helpers for the ten-way BCD round-robin arbiter.
package bcd_arb_pkg;
    localparam int         N_REQ     = 10;
    localparam logic [3:0] CODE_NONE = 4'hF;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

    function automatic logic [3:0] next_idx(input logic [3:0] i);
        return (i >= 4'd9) ? 4'd0 : i + 4'd1;
    endfunction
endpackage

// File: rtl/bcd_sel_decode.sv
// BCD code to active-low one-of-ten select; codes 10-15 deselect everything.
module bcd_sel_decode
    import bcd_arb_pkg::*;
(
    input  logic [3:0]       code,
    output logic [N_REQ-1:0] sel_n
);
    always_comb begin
        sel_n = '1;
        if (code < 4'(N_REQ))
            sel_n[code] = 1'b0;
    end
endmodule

// File: rtl/bcd_rr_arbiter.sv
// Ten-way break-before-make round-robin arbiter with BCD + one-of-ten outputs.
// Optional hold-time pre-emption enabled by defining BCD_ARB_TIMEOUT_EN.
module bcd_rr_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             gnt_valid,
    output logic [3:0]       gnt_code,
    output logic [N_REQ-1:0] gnt_n,
    output logic             timeout
);
    arb_state_t       state;
    logic [3:0]       ptr;
    logic [N_REQ-1:0] rot;
    logic [3:0]       off, win, code_d;
    logic [N_REQ-1:0] sel_n_d;
    logic             any_req, voluntary, hold_hit, release_now, forced;

    function automatic logic [3:0] wrap_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 5'(N_REQ)) ? 4'(s - 5'(N_REQ)) : s[3:0];
    endfunction

    // Rotate so ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        rot = '0;
        off = '0;
        for (int k = 0; k < N_REQ; k++)
            rot[k] = req[wrap_add(ptr, 4'(k))];
        for (int k = N_REQ - 1; k >= 0; k--)
            if (rot[k]) off = 4'(k);
        win     = wrap_add(ptr, off);
        any_req = |req;
    end

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;

    // Release fires on the edge at which the count would reach MAX_HOLD.
    assign hold_hit = (state == GRANT) && (int'(hold_cnt) + 1 >= MAX_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= '0;
        else if (state != GRANT)
            hold_cnt <= '0;
        else if (hold_cnt != HW'(MAX_HOLD))
            hold_cnt <= hold_cnt + 1'b1;
    end
`else
    assign hold_hit = 1'b0;
`endif

    assign voluntary   = done | ~req[gnt_code];
    assign release_now = voluntary | hold_hit;
    assign forced      = hold_hit & ~voluntary;

    always_comb begin
        code_d = CODE_NONE;
        case (state)
            GRANT:   code_d = release_now ? CODE_NONE : gnt_code;
            default: code_d = any_req ? win : CODE_NONE;
        endcase
    end

    bcd_sel_decode u_dec (
        .code  (code_d),
        .sel_n (sel_n_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_valid <= 1'b0;
            gnt_code  <= CODE_NONE;
            gnt_n     <= '1;
            timeout   <= 1'b0;
        end else begin
            gnt_valid <= (code_d != CODE_NONE);
            gnt_code  <= code_d;
            gnt_n     <= sel_n_d;
            timeout   <= 1'b0;
            case (state)
                GRANT: begin
                    if (release_now) begin
                        state   <= GAP;
                        timeout <= forced;
                    end
                end
                default: begin
                    if (any_req) begin
                        state <= GRANT;
                        ptr   <= next_idx(win);
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_rr_arbiter.sv
// Directed self-checking bench for bcd_rr_arbiter; expected owners go through a scoreboard queue.
module tb_bcd_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] req = '0;
    logic       done = 1'b0;
    logic       gnt_valid;
    logic [3:0] gnt_code;
    logic [9:0] gnt_n;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int sb[$];

    bcd_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_code  (gnt_code),
        .gnt_n     (gnt_n),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(gnt_valid), 32'd0);
        chk({tag, ".code"},  32'(gnt_code),  32'hF);
        chk({tag, ".gnt_n"}, 32'(gnt_n),     32'h3FF);
    endtask

    task automatic chk_grant(input string tag);
        int         e;
        logic [9:0] en;
        e  = (sb.size() > 0) ? sb.pop_front() : 15;
        en = ~(10'd1 << e);
        chk({tag, ".valid"}, 32'(gnt_valid), 32'd1);
        chk({tag, ".code"},  32'(gnt_code),  32'(e));
        chk({tag, ".gnt_n"}, 32'(gnt_n),     32'(en));
    endtask

    initial begin
        repeat (2) step();
        chk_idle("reset");
        chk("reset.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        step();

        // single requester, done pulse, re-grant after one gap cycle
        req = 10'h008; sb.push_back(3);
        step(); chk_grant("single");
        done = 1'b1;
        step(); done = 1'b0; chk_idle("single_gap");
        sb.push_back(3);
        step(); chk_grant("single_regrant");
        req = '0;
        step(); chk_idle("single_drop");
        step();

        // fairness with wrap: ptr=4, so 9 is served first
        req = 10'h201;
        for (int i = 0; i < 4; i++) begin
            sb.push_back((i % 2 == 0) ? 9 : 0);
            step(); chk_grant("fair");
            done = 1'b1;
            step(); done = 1'b0; chk_idle("fair_gap");
        end
        req = '0;
        step();

        // priority: owner 5 drops, then 6, 7, 0
        req = 10'h020; sb.push_back(5);
        step(); chk_grant("prio5");
        req = 10'h0C1;
        step(); chk_idle("prio_gap5");
        sb.push_back(6); step(); chk_grant("prio6");
        done = 1'b1; step(); done = 1'b0; chk_idle("prio_gap6");
        sb.push_back(7); step(); chk_grant("prio7");
        done = 1'b1; step(); done = 1'b0; chk_idle("prio_gap7");
        sb.push_back(0); step(); chk_grant("prio0");

        // done and req drop together: one release, ptr advances once (to 1)
        done = 1'b1; req = 10'h0C2;
        step(); done = 1'b0; chk_idle("simul_gap");
        sb.push_back(1); step(); chk_grant("simul_next");
        req = '0;
        step(); step(); chk_idle("simul_idle");

        // hold limit: 4 grant cycles then forced release
        req = 10'h004; sb.push_back(2);
        step(); chk_grant("hold");
        chk("hold.to0", 32'(timeout), 32'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("hold.valid", 32'(gnt_valid), 32'd1);
            chk("hold.to", 32'(timeout), 32'd0);
        end
`ifdef BCD_ARB_TIMEOUT_EN
        step();
        chk_idle("tmo_gap");
        chk("tmo.pulse", 32'(timeout), 32'd1);
        sb.push_back(2);
        step(); chk_grant("tmo_regrant");
        chk("tmo.pulse_end", 32'(timeout), 32'd0);
`else
        for (int i = 0; i < 8; i++) begin
            step();
            chk("hold_long.code", 32'(gnt_code), 32'd2);
            chk("hold_long.to", 32'(timeout), 32'd0);
        end
`endif
        req = '0;
        step(); step(); chk_idle("hold_idle");

        // async reset mid-grant, then first grant is code 0 (ptr was 3)
        req = 10'h3FF; sb.push_back(3);
        step(); chk_grant("pre_rst");
        #2 rst = 1'b1;
        #1 chk_idle("async_rst");
        rst = 1'b0;
        sb.push_back(0);
        step(); chk_grant("post_rst");
        req = '0;
        step(); step();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
